// File: rtl/ucc_state_monitor.sv
// Tracks PC against the UCC region: classifies each PC, runs the notUCC/inUCC/IRQ/RST
// machine with a watchdog, latches the outside caller's return address and raises a reset request.
module ucc_state_monitor #(
  parameter logic [15:0] UCC_MIN       = 16'hE000,
  parameter logic [15:0] UCC_MAX       = 16'hE0FF,
  parameter logic [15:0] UCC_ENTRY     = 16'hE000,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          MAX_CYCLES    = 1024,
  parameter bit          IRQ_ALLOWED   = 1'b0
) (
  input  logic        clk,
  input  logic        system_reset_n,
  input  logic [15:0] pc,
  input  logic        call_valid,
  input  logic [2:0]  call_len,
  input  logic        irq_taken,
  output logic [1:0]  ucc_state,
  output logic        outside_ucc,
  output logic [15:0] op_dest,
  output logic        reset
);

  typedef enum logic [1:0] {
    NOT_UCC = 2'b00,
    IN_UCC  = 2'b01,
    IRQ     = 2'b10,
    RST     = 2'b11
  } state_t;

  localparam logic [10:0] WDOG_LAST = 11'(MAX_CYCLES - 1);

  state_t      state, state_nxt;
  logic [10:0] wdog, wdog_nxt;

  always_ff @(posedge clk) begin
    if (!system_reset_n) begin
      state   <= NOT_UCC;
      wdog    <= '0;
      op_dest <= '0;
      reset   <= 1'b0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      reset <= (state_nxt == RST);
      // Only calls made from outside the region name a valid return target.
      if (call_valid && outside_ucc)
        op_dest <= pc + {13'd0, call_len};
    end
  end

  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    case (state)
      NOT_UCC: begin
        if (!outside_ucc && pc != UCC_ENTRY)
          state_nxt = RST;
        else if (pc == UCC_ENTRY) begin
          state_nxt = IN_UCC;
          wdog_nxt  = '0;
        end
      end
      IN_UCC: begin
        if (wdog == WDOG_LAST)
          state_nxt = RST;
        else if (irq_taken)
          state_nxt = IRQ_ALLOWED ? IRQ : RST;
        else if (outside_ucc)
          state_nxt = NOT_UCC;
        else if (wdog != '1)
          wdog_nxt = wdog + 11'd1;
      end
      // Returning from the handler resumes the same watchdog budget.
      IRQ: begin
        if (!outside_ucc)
          state_nxt = IN_UCC;
      end
      RST: begin
        if (pc == RESET_HANDLER)
          state_nxt = NOT_UCC;
      end
      default: state_nxt = NOT_UCC;
    endcase
  end

  always_comb begin
    outside_ucc = (pc < UCC_MIN) || (pc > UCC_MAX);
    ucc_state   = state;
  end

endmodule

// File: tb/tb_ucc_state_monitor.sv
// Bench for ucc_state_monitor: two instances (IRQs fatal / tolerated), table vectors,
// hand sequences for IRQ and watchdog, then random traffic against a behavioural model.
module tb_ucc_state_monitor;
  localparam int MAXC = 8;

  logic        clk = 1'b0;
  logic        system_reset_n;
  logic [15:0] pc;
  logic        call_valid;
  logic [2:0]  call_len;
  logic        irq_taken;
  logic [1:0]  st0, st1;
  logic        out0, out1, rst0, rst1;
  logic [15:0] op0, op1;

  always #5 clk = ~clk;

  ucc_state_monitor #(.MAX_CYCLES(MAXC), .IRQ_ALLOWED(1'b0)) dut0 (
    .clk(clk), .system_reset_n(system_reset_n), .pc(pc), .call_valid(call_valid),
    .call_len(call_len), .irq_taken(irq_taken), .ucc_state(st0), .outside_ucc(out0),
    .op_dest(op0), .reset(rst0));

  ucc_state_monitor #(.MAX_CYCLES(MAXC), .IRQ_ALLOWED(1'b1)) dut1 (
    .clk(clk), .system_reset_n(system_reset_n), .pc(pc), .call_valid(call_valid),
    .call_len(call_len), .irq_taken(irq_taken), .ucc_state(st1), .outside_ucc(out1),
    .op_dest(op1), .reset(rst1));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: per-instance mode, cycles spent inside, saved return address, reset flag.
  int  m_st[2], m_wd[2], m_op[2], m_rq[2];
  bit  model_ok = 0;

  function automatic bit inside_reg(input int a);
    return a >= 'hE000 && a <= 'hE0FF;
  endfunction

  function automatic void model_step(input int k, input bit allowed, input bit rn, input int p,
                                     input bit cv, input int len, input bit irq);
    if (!rn) begin
      m_st[k] = 0; m_wd[k] = 0; m_op[k] = 0; m_rq[k] = 0;
      return;
    end
    if (cv && !inside_reg(p)) m_op[k] = (p + len) % 65536;
    case (m_st[k])
      0: if (inside_reg(p) && p != 'hE000) m_st[k] = 3;
         else if (p == 'hE000) begin m_st[k] = 1; m_wd[k] = 0; end
      1: if (m_wd[k] == MAXC - 1) m_st[k] = 3;
         else if (irq) m_st[k] = allowed ? 2 : 3;
         else if (!inside_reg(p)) m_st[k] = 0;
         else m_wd[k] = (m_wd[k] + 1 > 2047) ? 2047 : m_wd[k] + 1;
      2: if (inside_reg(p)) m_st[k] = 1;
      default: if (p == 0) m_st[k] = 0;
    endcase
    m_rq[k] = (m_st[k] == 3);
  endfunction

  task automatic cyc(input bit rn, input logic [15:0] p, input bit cv, input logic [2:0] len,
                     input bit irq);
    bit exp_out;
    @(negedge clk);
    system_reset_n = rn; pc = p; call_valid = cv; call_len = len; irq_taken = irq;
    #1;
    exp_out = !inside_reg(int'(p));
    chk("outside0", int'(out0), int'(exp_out));
    chk("outside1", int'(out1), int'(exp_out));
    @(posedge clk);
    model_step(0, 1'b0, rn, int'(p), cv, int'(len), irq);
    model_step(1, 1'b1, rn, int'(p), cv, int'(len), irq);
    if (!rn) model_ok = 1;
    #1;
    if (model_ok) begin
      chk("m_state0", int'(st0), m_st[0]);
      chk("m_reset0", int'(rst0), m_rq[0]);
      chk("m_op0",    int'(op0), m_op[0]);
      chk("m_state1", int'(st1), m_st[1]);
      chk("m_reset1", int'(rst1), m_rq[1]);
      chk("m_op1",    int'(op1), m_op[1]);
    end
  endtask

  typedef struct {
    bit          rn;
    logic [15:0] pc;
    bit          cv;
    logic [2:0]  len;
    logic [1:0]  e_st;
    logic [15:0] e_op;
    bit          e_rst;
  } vec_t;

  vec_t vecs[12];

  initial begin
    system_reset_n = 1'b1; pc = 16'h4000; call_valid = 0; call_len = 0; irq_taken = 0;

    vecs[0]  = '{0, 16'hE010, 0, 3'd0, 2'b00, 16'h0000, 0};
    vecs[1]  = '{1, 16'h1000, 1, 3'd4, 2'b00, 16'h1004, 0};
    vecs[2]  = '{1, 16'hE000, 0, 3'd0, 2'b01, 16'h1004, 0};
    vecs[3]  = '{1, 16'hE002, 0, 3'd0, 2'b01, 16'h1004, 0};
    vecs[4]  = '{1, 16'hE004, 0, 3'd0, 2'b01, 16'h1004, 0};
    vecs[5]  = '{1, 16'h1004, 0, 3'd0, 2'b00, 16'h1004, 0};
    vecs[6]  = '{1, 16'hE004, 0, 3'd0, 2'b11, 16'h1004, 1};
    vecs[7]  = '{1, 16'h2000, 0, 3'd0, 2'b11, 16'h1004, 1};
    vecs[8]  = '{1, 16'h0000, 0, 3'd0, 2'b00, 16'h1004, 0};
    vecs[9]  = '{1, 16'hFFFE, 1, 3'd4, 2'b00, 16'h0002, 0};
    vecs[10] = '{1, 16'hE000, 1, 3'd2, 2'b01, 16'h0002, 0};
    vecs[11] = '{1, 16'h1000, 1, 3'd6, 2'b00, 16'h1006, 0};

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].rn, vecs[i].pc, vecs[i].cv, vecs[i].len, 1'b0);
      chk($sformatf("vec%0d_state", i), int'(st0), int'(vecs[i].e_st));
      chk($sformatf("vec%0d_op", i),    int'(op0), int'(vecs[i].e_op));
      chk($sformatf("vec%0d_reset", i), int'(rst0), int'(vecs[i].e_rst));
    end

    // IRQ inside the region: fatal for dut0, tolerated by dut1.
    cyc(1, 16'hE000, 0, 0, 0);
    chk("irq_enter0", int'(st0), 1); chk("irq_enter1", int'(st1), 1);
    cyc(1, 16'hE010, 0, 0, 1);
    chk("irq_st0", int'(st0), 3); chk("irq_rst0", int'(rst0), 1);
    chk("irq_st1", int'(st1), 2); chk("irq_rst1", int'(rst1), 0);
    cyc(1, 16'hE020, 0, 0, 0);
    chk("irq_ret0", int'(st0), 3); chk("irq_ret1", int'(st1), 1);
    cyc(1, 16'h0000, 0, 0, 0);
    chk("irq_exit0", int'(st0), 0); chk("irq_exit1", int'(st1), 0);

    // Watchdog: entry plus MAXC cycles inside trips RST on the last one.
    for (int i = 0; i <= MAXC; i++) begin
      cyc(1, 16'(16'hE000 + 2 * i), 0, 0, 0);
      chk($sformatf("wdog%0d_st", i), int'(st0), (i == MAXC) ? 3 : 1);
      chk($sformatf("wdog%0d_rst", i), int'(rst0), (i == MAXC) ? 1 : 0);
    end
    cyc(1, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] p;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    p = 16'hE000;
        2:       p = 16'h0000;
        3, 4, 5: p = 16'hE000 + 16'($urandom_range(0, 255));
        6:       p = 16'($urandom_range(16'hE100, 16'hFFFF));
        default: p = 16'($urandom_range(0, 16'hDFFF));
      endcase
      cyc(($urandom_range(0, 49) != 0), p, ($urandom_range(0, 3) == 0),
          3'(2 * $urandom_range(1, 3)), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
